pipe_ctrl: RTL and testbench

//  Pipeline sequencer around the if/if_id/id/id_ex/ex path. Arbitrates three stall/flush sources:
//  ex-stage jump/branch redirect, ex multi-cycle hold request, and id-stage load-use hazard.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl_perf_cnt.sv | 28 ++
 rtl/pipe_ctrl.sv | 100 ++++++++++
 tb/tb_pipe_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding, constants and the load-use hazard test for pipe_ctrl.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REDIR = 2'd1,
      ST_HOLD  = 2'd2
   } pipe_st_e;

   localparam logic [4:0]  ZERO_REG = 5'd0;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // x0 is hardwired, so a load targeting it can never create a hazard.
   function automatic logic load_use_hit(input logic       is_load,
                                         input logic [4:0] rd,
                                         input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return is_load && (rd != ZERO_REG) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Two free-running 32-bit event counters (redirects, pc-stall cycles); wrap at 2^32.
// One-cycle update latency; no backpressure, counts every qualifying cycle.
module pipe_ctrl_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        redir_i,
   input  logic        stall_i,
   output logic [31:0] perf_redir_o,
   output logic [31:0] perf_stall_o
);

   logic [31:0] redir_q;
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         redir_q <= '0;
         stall_q <= '0;
      end else begin
         if (redir_i) redir_q <= redir_q + 32'd1;
         if (stall_i) stall_q <= stall_q + 32'd1;
      end
   end

   assign perf_redir_o = redir_q;
   assign perf_stall_o = stall_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates ex hold > ex redirect > id load-use into pc/if_id/id_ex controls.
// Controls are combinational in the request cycle; optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int REDIR_CYC = 1,
   parameter int HOLD_MAX  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_en_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              hold_req_i,
   input  logic              ex_is_load_i,
   input  logic [4:0]        ex_rd_addr_i,
   input  logic [4:0]        id_rs1_addr_i,
   input  logic [4:0]        id_rs2_addr_i,
   output logic              pc_jump_en_o,
   output logic [ADDR_W-1:0] pc_jump_addr_o,
   output logic              stall_pc_o,
   output logic              stall_if_id_o,
   output logic              flush_if_id_o,
   output logic              flush_id_ex_o,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0]       perf_redir_o,
   output logic [31:0]       perf_stall_o,
`endif
   output logic              hold_timeout_o
);

   localparam int             HC_W       = $clog2(HOLD_MAX + 1);
   localparam logic [HC_W-1:0] HOLD_LIM  = HC_W'(HOLD_MAX);
   localparam logic [3:0]     REDIR_INIT = 4'(REDIR_CYC);
   localparam bit             REDIR_EN   = (REDIR_CYC > 0);

   pipe_st_e          state_q;
   logic [3:0]        redir_cnt_q;
   logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic              timeout_q;
   logic              hold_act, jump_act, lu_act;

   // Requests are gated by rst so every output reads 0 while reset is asserted.
   assign hold_act = !rst && hold_req_i;
   assign jump_act = !rst && jump_en_i && !hold_req_i;
   assign lu_act   = !rst && !hold_req_i && !jump_en_i && (state_q != ST_REDIR) &&
                     load_use_hit(ex_is_load_i, ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i);

   always_comb begin
      hold_cnt_d = '0;
      if (hold_req_i) hold_cnt_d = (hold_cnt_q == HOLD_LIM) ? hold_cnt_q : hold_cnt_q + HC_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         redir_cnt_q <= '0;
         hold_cnt_q  <= '0;
         addr_q      <= '0;
         timeout_q   <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         if (hold_req_i) begin
            state_q     <= ST_HOLD;
            redir_cnt_q <= '0;
            if (hold_cnt_d == HOLD_LIM) timeout_q <= 1'b1;
         end else if (jump_en_i) begin
            addr_q      <= jump_addr_i;
            state_q     <= REDIR_EN ? ST_REDIR : ST_IDLE;
            redir_cnt_q <= REDIR_INIT;
         end else if (state_q == ST_REDIR) begin
            redir_cnt_q <= redir_cnt_q - 4'd1;
            if (redir_cnt_q <= 4'd1) state_q <= ST_IDLE;
         end else begin
            state_q <= ST_IDLE;
         end
      end
   end

   assign pc_jump_en_o   = jump_act;
   assign pc_jump_addr_o = jump_act ? jump_addr_i : addr_q;
   assign stall_pc_o     = hold_act || lu_act;
   assign stall_if_id_o  = hold_act || lu_act;
   assign flush_if_id_o  = jump_act || (!rst && !hold_req_i && (state_q == ST_REDIR));
   assign flush_id_ex_o  = hold_act || jump_act || lu_act;
   assign hold_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
   pipe_ctrl_perf_cnt u_perf (
      .clk          (clk),
      .rst          (rst),
      .redir_i      (jump_act),
      .stall_i      (stall_pc_o),
      .perf_redir_o (perf_redir_o),
      .perf_stall_o (perf_stall_o)
   );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal checks plus randomized traffic against a cycle model.
module tb_pipe_ctrl;

   localparam int AW        = 32;
   localparam int REDIR_CYC = 1;
   localparam int HOLD_MAX  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          jump_en = 1'b0;
   logic [AW-1:0] jump_addr = '0;
   logic          hold_req = 1'b0;
   logic          ex_is_load = 1'b0;
   logic [4:0]    ex_rd = '0, rs1 = '0, rs2 = '0;
   logic          pc_jump_en, stall_pc, stall_if_id, flush_if_id, flush_id_ex, hold_timeout;
   logic [AW-1:0] pc_jump_addr;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]   perf_redir, perf_stall;
`endif

   int n_cmp = 0;
   int n_err = 0;

   pipe_ctrl #(.ADDR_W(AW), .REDIR_CYC(REDIR_CYC), .HOLD_MAX(HOLD_MAX)) dut (
      .clk            (clk),
      .rst            (rst),
      .jump_en_i      (jump_en),
      .jump_addr_i    (jump_addr),
      .hold_req_i     (hold_req),
      .ex_is_load_i   (ex_is_load),
      .ex_rd_addr_i   (ex_rd),
      .id_rs1_addr_i  (rs1),
      .id_rs2_addr_i  (rs2),
      .pc_jump_en_o   (pc_jump_en),
      .pc_jump_addr_o (pc_jump_addr),
      .stall_pc_o     (stall_pc),
      .stall_if_id_o  (stall_if_id),
      .flush_if_id_o  (flush_if_id),
      .flush_id_ex_o  (flush_id_ex),
`ifdef PIPE_CTRL_PERF_EN
      .perf_redir_o   (perf_redir),
      .perf_stall_o   (perf_stall),
`endif
      .hold_timeout_o (hold_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: bubbles left after a redirect, consecutive hold cycles, sticky timeout.
   int          m_redir_left = 0;
   int          m_hold_run   = 0;
   bit          m_timeout    = 0;
   logic [AW-1:0] m_addr     = '0;
   longint      m_perf_redir = 0;
   longint      m_perf_stall = 0;

   always @(negedge clk) begin
      bit e_jump, e_hold, e_lu, e_stall, e_fif, e_fie;
      logic [AW-1:0] e_addr;
      e_jump  = !rst && jump_en && !hold_req;
      e_hold  = !rst && hold_req;
      e_lu    = !rst && !hold_req && !jump_en && (m_redir_left == 0) && ex_is_load &&
                (ex_rd != 5'd0) && (ex_rd == rs1 || ex_rd == rs2);
      e_stall = e_hold || e_lu;
      e_fif   = e_jump || (!rst && !hold_req && m_redir_left > 0);
      e_fie   = e_hold || e_jump || e_lu;
      e_addr  = e_jump ? jump_addr : m_addr;
      chk("pc_jump_en",    {63'd0, pc_jump_en},   {63'd0, e_jump});
      chk("pc_jump_addr",  {32'd0, pc_jump_addr}, {32'd0, e_addr});
      chk("stall_pc",      {63'd0, stall_pc},     {63'd0, e_stall});
      chk("stall_if_id",   {63'd0, stall_if_id},  {63'd0, e_stall});
      chk("flush_if_id",   {63'd0, flush_if_id},  {63'd0, e_fif});
      chk("flush_id_ex",   {63'd0, flush_id_ex},  {63'd0, e_fie});
      chk("hold_timeout",  {63'd0, hold_timeout}, {63'd0, m_timeout});
`ifdef PIPE_CTRL_PERF_EN
      chk("perf_redir",    {32'd0, perf_redir},   64'(m_perf_redir % 64'h1_0000_0000));
      chk("perf_stall",    {32'd0, perf_stall},   64'(m_perf_stall % 64'h1_0000_0000));
`endif
      // advance the model to the state after the coming rising edge
      if (rst) begin
         m_redir_left = 0; m_hold_run = 0; m_timeout = 0; m_addr = '0;
         m_perf_redir = 0; m_perf_stall = 0;
      end else begin
         m_perf_redir += e_jump;
         m_perf_stall += e_stall;
         if (hold_req) begin
            m_redir_left = 0;
            if (m_hold_run < HOLD_MAX) m_hold_run++;
            if (m_hold_run >= HOLD_MAX) m_timeout = 1;
         end else begin
            m_hold_run = 0;
            if (jump_en) begin
               m_redir_left = REDIR_CYC;
               m_addr = jump_addr;
            end else if (m_redir_left > 0) begin
               m_redir_left--;
            end
         end
      end
   end

   task automatic next;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      jump_en = 0; hold_req = 0; ex_is_load = 0; ex_rd = 0; rs1 = 0; rs2 = 0;
   endtask

   initial begin
      bit hold_state;
      // reset held with a pending jump
      rst = 1; jump_en = 1; jump_addr = 32'h0000_1234;
      for (int i = 0; i < 3; i++) begin
         mid;
         chk("rst_jump_en", {63'd0, pc_jump_en}, 64'd0);
         chk("rst_flush",   {62'd0, flush_if_id, flush_id_ex}, 64'd0);
         chk("rst_addr",    {32'd0, pc_jump_addr}, 64'd0);
         next;
      end
      rst = 0;
      mid;
      chk("post_rst_jump", {63'd0, pc_jump_en}, 64'd1);
      next; idle_inputs; next; next;

      // redirect with one trailing if_id flush
      jump_en = 1; jump_addr = 32'h8000_0040;
      mid;
      chk("j_c0_en",    {63'd0, pc_jump_en}, 64'd1);
      chk("j_c0_addr",  {32'd0, pc_jump_addr}, 64'h8000_0040);
      chk("j_c0_flush", {62'd0, flush_if_id, flush_id_ex}, 64'd3);
      next; jump_en = 0; jump_addr = 32'hDEAD_BEEF;
      mid;
      chk("j_c1_flush", {62'd0, flush_if_id, flush_id_ex}, 64'd2);
      chk("j_c1_hold_addr", {32'd0, pc_jump_addr}, 64'h8000_0040);
      next;
      mid;
      chk("j_c2_quiet", {59'd0, pc_jump_en, stall_pc, stall_if_id, flush_if_id, flush_id_ex}, 64'd0);
      next;

      // load-use hazard, then an x0 non-hazard
      ex_is_load = 1; ex_rd = 5; rs2 = 5;
      mid;
      chk("lu_hit", {61'd0, stall_pc, stall_if_id, flush_id_ex}, 64'd7);
      next; ex_rd = 0; rs1 = 0; rs2 = 0;
      mid;
      chk("lu_x0", {61'd0, stall_pc, stall_if_id, flush_id_ex}, 64'd0);
      next; idle_inputs;

      // hold masks a simultaneous jump; jump taken when hold drops
      hold_req = 1; jump_en = 1; jump_addr = 32'h0000_0100;
      for (int i = 0; i < 4; i++) begin
         mid;
         chk("hold_j_stall", {61'd0, stall_pc, stall_if_id, flush_id_ex}, 64'd7);
         chk("hold_j_noj",   {62'd0, pc_jump_en, flush_if_id}, 64'd0);
         next;
      end
      hold_req = 0;
      mid;
      chk("hold_drop_jump", {63'd0, pc_jump_en}, 64'd1);
      next; idle_inputs; next;

      // hold timeout after HOLD_MAX cycles, sticky until reset
      hold_req = 1;
      for (int i = 1; i <= 10; i++) begin
         mid;
         chk("timeout_run", {63'd0, hold_timeout}, (i > HOLD_MAX) ? 64'd1 : 64'd0);
         next;
      end
      hold_req = 0;
      mid;
      chk("timeout_sticky", {63'd0, hold_timeout}, 64'd1);
      next; rst = 1; next; rst = 0;
      mid;
      chk("timeout_clr", {63'd0, hold_timeout}, 64'd0);
      next;

`ifdef PIPE_CTRL_PERF_EN
      for (int i = 0; i < 3; i++) begin
         jump_en = 1; jump_addr = 32'h40 * (i + 1); next; jump_en = 0; next; next;
      end
      hold_req = 1; repeat (4) next; hold_req = 0; next;
      mid;
      chk("perf_redir_3", {32'd0, perf_redir}, 64'd3);
      chk("perf_stall_4", {32'd0, perf_stall}, 64'd4);
      next;
`endif

      // randomized traffic; bursty holds so timeouts occur
      hold_state = 0;
      for (int c = 0; c < 3000; c++) begin
         if (hold_state) hold_state = ($urandom_range(0, 99) < 85);
         else            hold_state = ($urandom_range(0, 99) < 8);
         hold_req   = hold_state;
         rst        = ($urandom_range(0, 199) == 0);
         jump_en    = ($urandom_range(0, 99) < 25);
         jump_addr  = $urandom;
         ex_is_load = ($urandom_range(0, 1) == 1);
         ex_rd      = 5'($urandom_range(0, 3));
         rs1        = 5'($urandom_range(0, 3));
         rs2        = 5'($urandom_range(0, 3));
         next;
      end
      idle_inputs; rst = 0;
      next; next;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
